mux_scan_controller: RTL and testbench
======================================

Name: mux_scan_controller

Overview:
Upstream address sequencer and downstream sampler for the 4:1 structural multiplexer.
- Drives the mux select lines addr0/addr1 and scans the enabled inputs in round-robin order.
- Holds each address for a settle window, then captures the mux output into a per-channel sample register.
- Reports completion of each sweep to the consumer.

Parameters:
DWELL, 4, cycles each address is held before capture; legal range 1..2^CNT_W-1; DWELL=0 behaves as 1.
CNT_W, 8, width of the dwell counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a scan; sampled only in IDLE
single  input  1  1 = one sweep then IDLE; 0 = continuous sweeps; sampled with start
stop  input  1  request to end continuous scanning; sticky until honoured
chan_en  input  4  channel enable mask, bit i = mux input i
mux_out  input  1  output of the 4:1 mux
addr0  output  1  mux select LSB
addr1  output  1  mux select MSB; channel index = {addr1,addr0}
busy  output  1  high from first SETTLE cycle until return to IDLE
sample  output  4  bit i = last value captured from channel i
sample_valid  output  1  one-cycle pulse, one per capture
sweep_done  output  1  one-cycle pulse after capture of the last enabled channel

Behaviour:
- Reset (asynchronous, immediate, no clock edge needed): state=IDLE, {addr1,addr0}=00, busy=0, sample=0000, sample_valid=0, sweep_done=0, stop latch cleared, counter=0.
- States: IDLE, SETTLE. Capture is the final SETTLE cycle; there is no separate capture state.
- IDLE:
  - start=1 and chan_en!=0 at edge k: latch en_q=chan_en, latch mode=single, load the lowest enabled channel into addr, counter=DWELL-1, go to SETTLE.
  - After edge k: busy=1 and addr is valid.
  - start with chan_en=0000 is ignored: stay in IDLE, no pulses.
- SETTLE:
  - Addr is held stable; counter decrements each cycle.
  - On the edge where counter==0:
    - sample[ch] <= mux_out, captured as-is, including x.
    - sample_valid=1 for the following cycle.
    - addr advances to the next set bit of en_q above ch, wrapping to the lowest set bit.
    - counter reloads to DWELL-1.
- Sweep end = capture of the highest enabled channel. On that edge:
  - sweep_done=1 for one cycle, coincident with that capture's sample_valid.
  - If mode=single or the stop latch is set: go to IDLE, busy=0, addr held at its last value, stop latch cleared.
  - Otherwise: re-latch en_q=chan_en. If the new mask is 0, go to IDLE; else restart from its lowest set bit.
- Timing: with N enabled channels, the capture of the j-th channel (1-based) occurs at edge k+j*DWELL, and sweep_done is high the cycle after edge k+N*DWELL.
- chan_en changes mid-sweep are ignored until the sweep boundary.
- start while busy is ignored. stop while IDLE is ignored (not latched).
- A single enabled channel re-captures the same channel every DWELL cycles; in continuous mode sweep_done pulses each time.
- Unenabled sample bits retain their previous value.

Decomposition:
- Shared package mux_scan_pkg:
  - state encoding (IDLE, SETTLE)
  - NUM_CH=4 and ADDR_W=2
  - function next_enabled(mask, current) returning wrap-around next set bit and a last-channel flag
- One natural sub-module: rr_next_channel, a combinational round-robin next-index finder implementing next_enabled. Reusable for wider muxes.
- The remaining FSM, counter and sample register stay in mux_scan_controller.

Test Plan:
1. DWELL=4, single=1, chan_en=1111, mux model in0..in3=1,0,1,1:
   - addr held 00,01,10,11 for 4 cycles each
   - sample_valid pulses at +4,+8,+12,+16
   - sample=1101
   - sweep_done is one pulse after edge 16
   - busy falls after edge 16
2. chan_en=1010, sample preloaded 0101, in1=0, in3=0:
   - only addr 01 and 11 are visited
   - sweep_done after edge 8
   - sample=0101 (bits 0 and 2 untouched)
3. Continuous mode, chan_en=0011, stop pulsed during the second sweep:
   - that sweep completes
   - exactly 2 sweep_done pulses in total, then IDLE with busy=0
4. start with chan_en=0000: busy stays 0, addr stays 00, no pulses for 20 cycles.
5. start again while busy, and chan_en changed 1111->0001 mid-sweep:
   - current sweep still visits all 4 channels
   - in continuous mode, the next sweep visits ch0 only
6. rst_n driven low between clock edges mid-SETTLE:
   - all outputs are reset values immediately
   - after release, start restarts cleanly from the lowest enabled channel

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 4:1 mux address sequencer.
// Includes the round-robin search used to step through enabled channels.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned ADDR_W = 2;

  typedef enum logic [0:0] {
    StIdle,
    StSettle
  } state_e;

  // Returns {last, next}: next is the first set bit above current, wrapping to the
  // lowest set bit; last is set when no enabled channel lies above current.
  function automatic logic [ADDR_W:0] next_enabled(input logic [NUM_CH-1:0] mask,
                                                   input logic [ADDR_W-1:0] current);
    logic [ADDR_W-1:0] nxt;
    logic              found;
    nxt   = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(current))) begin
        nxt   = ADDR_W'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (mask[i]) nxt = ADDR_W'(i);
      end
    end
    return {~found, nxt};
  endfunction

endpackage

// File: rtl/rr_next_channel.sv
// Combinational round-robin next-index finder over an enable mask.
// Width follows the package constants so wider muxes only need a package change.
module rr_next_channel
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [ADDR_W-1:0] current,
  output logic [ADDR_W-1:0] next,
  output logic              last
);

  logic [ADDR_W:0] res;

  always_comb begin
    res  = next_enabled(mask, current);
    next = res[ADDR_W-1:0];
    last = res[ADDR_W];
  end

endmodule

// File: rtl/mux_scan_controller.sv
// Round-robin address sequencer and sampler for a 4:1 structural mux.
// Holds each enabled address for DWELL cycles, then captures mux_out into sample.
module mux_scan_controller
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              single,
  input  logic              stop,
  input  logic [NUM_CH-1:0] chan_en,
  input  logic              mux_out,
  output logic              addr0,
  output logic              addr1,
  output logic              busy,
  output logic [NUM_CH-1:0] sample,
  output logic              sample_valid,
  output logic              sweep_done
);

  // DWELL=0 is treated as a one-cycle dwell.
  localparam logic [CNT_W-1:0] Reload = (DWELL == 0) ? '0 : CNT_W'(DWELL - 1);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic              single_q, single_d;
  logic              stop_q, stop_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_CH-1:0] sample_q, sample_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] adv_ch, low_ch;
  logic              adv_last, unused_low_last;

  rr_next_channel u_adv (
    .mask    (en_q),
    .current (addr_q),
    .next    (adv_ch),
    .last    (adv_last)
  );

  // Searching from the top index always wraps, yielding the lowest enabled channel.
  rr_next_channel u_low (
    .mask    (chan_en),
    .current ({ADDR_W{1'b1}}),
    .next    (low_ch),
    .last    (unused_low_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      en_q     <= '0;
      single_q <= 1'b0;
      stop_q   <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      single_q <= single_d;
      stop_q   <= stop_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    single_d = single_q;
    stop_d   = stop_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && (chan_en != '0)) begin
          en_d     = chan_en;
          single_d = single;
          addr_d   = low_ch;
          cnt_d    = Reload;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (stop) stop_d = 1'b1;
        if (cnt_q == '0) begin
          sample_d[addr_q] = mux_out;
          valid_d          = 1'b1;
          cnt_d            = Reload;
          if (adv_last) begin
            done_d = 1'b1;
            if (single_q || stop_q || stop) begin
              state_d = StIdle;
              stop_d  = 1'b0;
            end else begin
              // Sweep boundary: pick up any mask change made during the sweep.
              en_d = chan_en;
              if (chan_en == '0) state_d = StIdle;
              else               addr_d  = low_ch;
            end
          end else begin
            addr_d = adv_ch;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy         = (state_q == StSettle);
    addr0        = addr_q[0];
    addr1        = addr_q[1];
    sample       = sample_q;
    sample_valid = valid_q;
    sweep_done   = done_q;
  end

endmodule

// File: tb/tb_mux_scan_controller.sv
// Directed bench for mux_scan_controller: table of single sweeps plus hand-written
// sequences for zero mask, continuous/stop, mid-sweep mask change and async reset.
module tb_mux_scan_controller;

  localparam int unsigned DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       single = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] chan_en = '0;
  logic [3:0] in_pat = '0;
  logic       mux_out;
  logic       addr0, addr1, busy, sample_valid, sweep_done;
  logic [3:0] sample;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign mux_out = in_pat[{addr1, addr0}];

  mux_scan_controller #(
    .DWELL (DWELL),
    .CNT_W (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .single       (single),
    .stop         (stop),
    .chan_en      (chan_en),
    .mux_out      (mux_out),
    .addr0        (addr0),
    .addr1        (addr1),
    .busy         (busy),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sweep_done   (sweep_done)
  );

  typedef struct {
    logic [3:0] en;
    logic [3:0] pat;
    logic [3:0] exp_sample;
    int         cycles;
    logic [1:0] lo;
    logic [1:0] hi;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input string tag, input logic [3:0] en, input logic [3:0] pat,
                            input logic [3:0] exp_sample, input int exp_cycles,
                            input logic [1:0] lo, input logic [1:0] hi);
    int         cycles;
    int         valids;
    int         first_valid;
    logic [3:0] visited;
    logic [1:0] prev;
    logic       done;
    chan_en = en;
    in_pat  = pat;
    single  = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_addr_first"}, {addr1, addr0}, lo);
    cycles = 0; valids = 0; first_valid = 0; visited = '0; done = 1'b0;
    while (!done && cycles < 200) begin
      prev = {addr1, addr0};
      tick();
      cycles++;
      if (sample_valid) begin
        valids++;
        visited[prev] = 1'b1;
        if (first_valid == 0) first_valid = cycles;
      end
      if (sweep_done) done = 1'b1;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_done_cycle"}, cycles, exp_cycles);
    check({tag, "_first_valid"}, first_valid, DWELL);
    check({tag, "_valids"}, valids, $countones(en));
    check({tag, "_visited"}, visited, en);
    check({tag, "_sample"}, sample, exp_sample);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_addr_hold"}, {addr1, addr0}, hi);
    tick();
    check({tag, "_done_pulse"}, sweep_done, 0);
  endtask

  initial begin
    int         cycles;
    int         dones;
    int         sweep;
    int         done_cyc0;
    int         done_cyc1;
    logic [3:0] vis0, vis1;
    logic [1:0] prev;
    logic       bad;

    vecs[0] = '{4'b1111, 4'b1101, 4'b1101, 16, 2'd0, 2'd3};
    vecs[1] = '{4'b1111, 4'b0101, 4'b0101, 16, 2'd0, 2'd3};
    vecs[2] = '{4'b1010, 4'b0000, 4'b0101,  8, 2'd1, 2'd3};
    vecs[3] = '{4'b0100, 4'b0000, 4'b0001,  4, 2'd2, 2'd2};
    vecs[4] = '{4'b1001, 4'b1111, 4'b1001,  8, 2'd0, 2'd3};
    vecs[5] = '{4'b0110, 4'b1111, 4'b1111,  8, 2'd1, 2'd2};

    // Reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_addr", {addr1, addr0}, 0);
    check("rst_sample", sample, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_done", sweep_done, 0);
    #12 rst_n = 1'b1;
    tick();

    // Zero mask start is ignored
    chan_en = 4'b0000;
    start   = 1'b1;
    single  = 1'b1;
    tick();
    start = 1'b0;
    bad   = 1'b0;
    repeat (20) begin
      tick();
      if (busy || sample_valid || sweep_done || ({addr1, addr0} != 2'd0)) bad = 1'b1;
    end
    check("zero_mask_idle", bad, 0);

    for (int i = 0; i < 6; i++) begin
      run_single($sformatf("v%0d", i), vecs[i].en, vecs[i].pat, vecs[i].exp_sample,
                 vecs[i].cycles, vecs[i].lo, vecs[i].hi);
    end

    // Continuous mode, stop during second sweep
    chan_en = 4'b0011;
    in_pat  = 4'b0001;
    single  = 1'b0;
    start   = 1'b1;
    tick();
    start  = 1'b0;
    cycles = 0;
    dones  = 0;
    while (busy && cycles < 200) begin
      tick();
      cycles++;
      if (sweep_done) dones++;
      stop = (cycles == 10);
    end
    stop = 1'b0;
    check("cont_dones", dones, 2);
    check("cont_cycles", cycles, 16);
    check("cont_busy", busy, 0);
    check("cont_sample", sample, 4'b1101);
    tick();
    check("cont_idle_done", sweep_done, 0);

    // Mid-sweep mask change and start while busy
    chan_en = 4'b1111;
    in_pat  = 4'b1010;
    single  = 1'b0;
    start   = 1'b1;
    tick();
    start  = 1'b0;
    cycles = 0; sweep = 0; vis0 = '0; vis1 = '0; done_cyc0 = 0; done_cyc1 = 0;
    while (busy && cycles < 200) begin
      prev = {addr1, addr0};
      tick();
      cycles++;
      if (sample_valid) begin
        if (sweep == 0) vis0[prev] = 1'b1;
        else if (sweep == 1) vis1[prev] = 1'b1;
      end
      if (sweep_done) begin
        if (sweep == 0) done_cyc0 = cycles;
        else if (sweep == 1) done_cyc1 = cycles;
        sweep++;
      end
      start = (cycles == 2);
      if (cycles == 2) chan_en = 4'b0001;
      stop = (cycles == 17);
    end
    start = 1'b0;
    stop  = 1'b0;
    check("chg_sweeps", sweep, 2);
    check("chg_vis0", vis0, 4'b1111);
    check("chg_vis1", vis1, 4'b0001);
    check("chg_done0", done_cyc0, 16);
    check("chg_done1", done_cyc1, 20);
    check("chg_busy", busy, 0);
    check("chg_sample", sample, 4'b1010);

    // Asynchronous reset mid-SETTLE
    chan_en = 4'b0110;
    in_pat  = 4'b1111;
    single  = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_addr", {addr1, addr0}, 0);
    check("arst_sample", sample, 0);
    check("arst_valid", sample_valid, 0);
    check("arst_done", sweep_done, 0);
    #2 rst_n = 1'b1;
    tick();
    run_single("arst_restart", 4'b0110, 4'b1111, 4'b0110, 8, 2'd1, 2'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
